// File: rtl/approx_err_monitor.sv
// Error-metrics collector for an 8x8 approximate multiplier: recomputes the exact
// product and reports error totals once per window of 2^WIN_LOG2 samples.
module approx_err_monitor #(
   parameter int WIN_LOG2 = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [7:0]                a,
   input  logic [7:0]                b,
   input  logic [15:0]               prod8,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [16+WIN_LOG2-1:0]    ed_sum,
   output logic [15:0]               ed_max,
   output logic [WIN_LOG2:0]         err_cnt,
   output logic [7:0]                worst_a,
   output logic [7:0]                worst_b
);

   localparam logic [1:0] ACCUM  = 2'd0;
   localparam logic [1:0] DRAIN  = 2'd1;
   localparam logic [1:0] REPORT = 2'd2;

   localparam logic [WIN_LOG2:0] LAST_IDX = {1'b0, {WIN_LOG2{1'b1}}};

   // The difference is at most 65535 in magnitude, so the absolute value fits 16 bits.
   function automatic logic [15:0] abs_ed(input logic signed [16:0] diff);
      logic signed [16:0] neg;
      neg = -diff;
      return diff[16] ? neg[15:0] : diff[15:0];
   endfunction

   logic [1:0]          state;
   logic [WIN_LOG2:0]   n_acc;
   logic                accept;

   logic                vld_p1;
   logic [7:0]          a_p1;
   logic [7:0]          b_p1;
   logic [15:0]         prod_p1;
   logic [15:0]         exact_p1;
   logic signed [16:0]  diff_p1;

   logic                vld_p2;
   logic [15:0]         ed_p2;
   logic                nz_p2;
   logic [7:0]          a_p2;
   logic [7:0]          b_p2;

   assign in_ready  = rst_n & (state == ACCUM);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state == REPORT);

   assign exact_p1 = {8'd0, a_p1} * {8'd0, b_p1};
   assign diff_p1  = $signed({1'b0, exact_p1}) - $signed({1'b0, prod_p1});

   // ---- stage p1: capture operands at the accept edge
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p1    <= a;
         b_p1    <= b;
         prod_p1 <= prod8;
      end
   end

   // ---- stage p2: exact product and error distance
   always_ff @(posedge clk) begin
      if (vld_p1) begin
         ed_p2 <= abs_ed(diff_p1);
         nz_p2 <= (diff_p1 != 17'sd0);
         a_p2  <= a_p1;
         b_p2  <= b_p1;
      end
   end

   // ---- accumulation and window control
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ACCUM;
         n_acc   <= '0;
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         ed_sum  <= '0;
         ed_max  <= '0;
         err_cnt <= '0;
         worst_a <= '0;
         worst_b <= '0;
      end else begin
         vld_p1 <= accept;
         vld_p2 <= vld_p1;

         if (vld_p2) begin
            ed_sum  <= ed_sum + (16+WIN_LOG2)'(ed_p2);
            err_cnt <= err_cnt + (WIN_LOG2+1)'(nz_p2);
            if (ed_p2 > ed_max) begin
               ed_max  <= ed_p2;
               worst_a <= a_p2;
               worst_b <= b_p2;
            end
         end

         case (state)
            ACCUM: begin
               if (accept) begin
                  if (n_acc == LAST_IDX) begin
                     n_acc <= '0;
                     state <= DRAIN;
                  end else begin
                     n_acc <= n_acc + 1'b1;
                  end
               end
            end
            // Only the window's final sample is in flight once p1 has emptied.
            DRAIN: begin
               if (vld_p2 && !vld_p1) state <= REPORT;
            end
            REPORT: begin
               if (out_ready) begin
                  ed_sum  <= '0;
                  ed_max  <= '0;
                  err_cnt <= '0;
                  worst_a <= '0;
                  worst_b <= '0;
                  vld_p1  <= 1'b0;
                  vld_p2  <= 1'b0;
                  state   <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Streaming error-metrics collector placed directly downstream of the 8x8 approximate multiplier (`ac_1444` and siblings). Each cycle it can accept one operand pair and the multiplier's approximate 16-bit product. It recomputes the exact product in a two-stage pipeline and accumulates error statistics over a fixed window of 2^WIN_LOG2 samples. At the end of each window it presents the totals on a valid/ready output port for the characterisation harness.

## Interface
- WIN_LOG2, default 8: window length is 2^WIN_LOG2 samples; legal range 1..16.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- in_valid, in, 1: the sample on a/b/prod8 is valid.
- in_ready, out, 1: block accepts a sample this cycle.
- a, in, 8: multiplicand, unsigned.
- b, in, 8: multiplier, unsigned.
- prod8, in, 16: approximate product from the multiplier under test.
- out_valid, out, 1: window results are valid and held.
- out_ready, in, 1: consumer takes the results.
- ed_sum, out, 16+WIN_LOG2: sum of error distances |a*b − prod8| over the window.
- ed_max, out, 16: largest error distance in the window.
- err_cnt, out, WIN_LOG2+1: number of samples with nonzero error distance.
- worst_a, out, 8: value of a for the first sample that reached ed_max.
- worst_b, out, 8: value of b for the same sample.

## Operation
- Handshake: a sample is accepted on any edge where in_valid & in_ready. in_ready = rst_n & (state == ACCUM). No combinational path runs from in_valid to in_ready.
- Stage S1 registers a, b, prod8 and the valid bit v1 at the accept edge.
- Stage S2 registers the following at the next edge, with valid bit v2:
  - exact = a*b (16-bit, at most 65025);
  - ed = |exact − prod8| (16-bit, never overflows; prod8 above exact is legal);
  - nz = (ed != 0);
  - the operands from S1.
- Accumulate on each edge with v2 = 1:
  - ed_sum += ed; width 16+WIN_LOG2, so it cannot overflow within a window.
  - err_cnt += nz.
  - If ed > ed_max (strictly greater), set ed_max = ed and capture worst_a/worst_b from S2. Ties keep the earlier sample.
- Sample counter n_acc (WIN_LOG2+1 bits) increments on each accept.
- States:
  - ACCUM: in_ready = 1. The edge that accepts sample number 2^WIN_LOG2 moves to DRAIN and clears n_acc.
  - DRAIN: in_ready = 0. Waits for the pipeline to empty. The edge that accumulates the last sample (v2 = 1, v1 = 0) moves to REPORT.
  - REPORT: out_valid = 1, in_ready = 0. All result outputs are held stable. On out_valid & out_ready, clear ed_sum, ed_max, err_cnt, worst_a, worst_b, v1 and v2, and move to ACCUM.
- in_valid is ignored outside ACCUM. a, b and prod8 are sampled only at accept edges.
- Reset, including mid-window or mid-REPORT: state = ACCUM and n_acc = 0. v1, v2 and every output register go to 0, so out_valid = 0 and all result outputs read 0. Partial-window data is discarded.

## Timing
- During reset, in_ready = 0. From the first cycle after rst_n rises, in_ready = 1.
- Per-sample latency: a sample accepted at edge k enters S1 at k, enters S2 at k+1, and is accumulated at k+2.
- Last sample of a window accepted at edge k:
  - in_ready falls after edge k;
  - out_valid rises after edge k+2, with the results already including that sample.
- The result handshake at edge m clears the results and restores in_ready = 1 after edge m.
- Minimum window period: 2^WIN_LOG2 + 3 cycles with out_ready held at 1.
- Throughput: one sample per cycle within ACCUM. Gaps in in_valid just stretch the window.

## Test plan
- **Exact samples** (WIN_LOG2 = 2): 4× (a=3, b=5, prod8=15).
  - Required: out_valid exactly 2 cycles after the 4th accept; ed_sum=0, ed_max=0, err_cnt=0, worst_a=0, worst_b=0.
- **Mixed errors** (WIN_LOG2 = 2): (10,10,96), (255,255,65025), (7,9,70), (16,16,256).
  - Required: ed_sum=11, ed_max=7, err_cnt=2, worst_a=7, worst_b=9.
- **Over-approximation at full width** (WIN_LOG2 = 2): 4× (0, 0, 65535).
  - Required: ed_sum=262140 with no wrap; ed_max=65535; err_cnt=4; worst operands (0,0) from the first sample.
- **Tie on maximum**: samples with ed 5 at (2,3) and then ed 5 at (4,4).
  - Required: worst_a=2, worst_b=3.
- **Backpressure**: hold out_ready=0 for 10 cycles in REPORT while in_valid=1 with changing data.
  - Required: results stay unchanged and in_ready stays 0. On the out_ready handshake the results clear to 0, and in_ready=1 on the next cycle; the next window counts from 1.
- **Reset mid-window**: pulse rst_n=0 for 1 cycle after 2 of 4 accepted samples with errors.
  - Required: all outputs read 0. A fresh 4-sample window afterwards reports only post-reset samples.
